score_hex_display: RTL
======================

Name: score_hex_display

Overview:
Display back-end sitting directly downstream of the game-select mux. Takes the four selected 5-bit display values and the 5-bit result/LED vector. Converts each value sequentially to two decimal digits and drives eight active-low 7-segment displays. Blinks the LEDs while the result vector is non-zero.

Parameters:
BLINK_DIV, 25000000, clock cycles per LED blink half-period (0.5 s at 50 MHz); legal range 2 to 2^26-1
BLANK_LZ, 1, 1 = tens digit blank when 0; 0 = tens digit shows "0"

Ports:
Clock  input  1  system clock (50 MHz)
reset_n  input  1  asynchronous active-low reset
val1  input  5  value for pair HEX7:HEX6 (leftmost)
val2  input  5  value for pair HEX5:HEX4
val3  input  5  value for pair HEX3:HEX2
val4  input  5  value for pair HEX1:HEX0 (rightmost)
led_in  input  5  result vector from selected game
HEX0..HEX7  output  7 each  active-low segments; bit0=a … bit6=g
LEDR  output  5  blinking copy of led_in

Behaviour:
- Reset (async, reset_n=0): all HEX = 7'b1111111 (blank); LEDR = 0; converter FSM in LOAD with channel index 0; blink counter 0; blink phase = on.
- All outputs registered. No combinational input-to-output path.
- Converter FSM, channels are serviced round-robin 0→1→2→3→0:
  - LOAD (1 cycle): snapshot val[ch] into rem (5 bits); tens=0. Go to SUB.
  - SUB (1 cycle per step): if rem>=10, then rem=rem-10 and tens=tens+1, stay in SUB. Else go to DONE.
  - DONE (1 cycle): write both digit registers of channel ch in the same cycle (atomic pair update). ch=ch+1 mod 4. Go to LOAD.
- Steps per value: 0–9 take 0 SUB steps, 10–19 take 1, 20–29 take 2, 30–31 take 3. Each SUB state also spends one final compare cycle (rem<10). Maximum 6 cycles per channel.
- Full refresh of all four channels takes at most 24 cycles.
- A change on valN appears on its HEX pair within 48 cycles worst case.
- Input changes after LOAD do not affect a conversion in progress. The new value is picked up on the next visit.
- Digit encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Tens digit is at most 3.
- If BLANK_LZ=1 and tens=0, the tens HEX = 1111111. The units digit is always shown, so value 0 displays as " 0".
- Blink logic:
  - led_in==0: LEDR=0 next cycle; counter cleared; phase set to on.
  - led_in!=0: the phase starts on, so LEDR=led_in on the next cycle. The counter increments each cycle. At count BLINK_DIV-1 the counter wraps to 0 and the phase toggles.
  - Phase on: LEDR follows the live led_in (registered).
  - Phase off: LEDR=0.
- led_in returning to 0 mid-blink: LEDR=0 next cycle and the blink restarts cleanly on the next non-zero value.
- Counter width is 26 bits. BLINK_DIV must fit in it.
- Reset asserted mid-conversion: everything returns to the reset state immediately. After release, conversion restarts at channel 0, LOAD. No partially converted digit is ever written.

Test Plan:
1. Reset, then all val=0 with BLANK_LZ=1. Within 24 cycles each pair shows tens=1111111, units=1000000. LEDR=0.
2. val1=31, val2=10, val3=9, val4=25, held. After 48 cycles:
   - HEX7/6=0110000/1111001
   - HEX5/4=1111001/1000000
   - HEX3/2=1111111/0010000
   - HEX1/0=0100100/0010010
3. val4 changed from 25 to 7 while channel 3 is in SUB. The same refresh still writes 25. The next visit writes blank/1111000. No mixed-digit frame appears.
4. BLINK_DIV=4 (sim), led_in=5'b10101 held. LEDR=10101 for 4 cycles, then 0 for 4 cycles, repeating. Set led_in=0: LEDR=0 on the next cycle.
5. Pulse reset_n low asynchronously, between clock edges, mid-conversion and mid-blink. HEX all 1111111 and LEDR=0 without a clock edge. Operation resumes from channel 0 after release.
6. BLANK_LZ=0, val2=3. HEX5=1000000, HEX4=0110000.

Source files
------------

// File: rtl/score_hex_display.sv
// Score display back-end: serial binary-to-BCD conversion of four 5-bit values
// onto eight active-low 7-segment digits, plus a blinking copy of the result LEDs.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | snapshot the selected channel value into rem, clear tens
// SUB   | subtract ten per cycle while rem >= 10, counting tens
// DONE  | write the channel's tens/units pair together, advance channel
module score_hex_display #(
    parameter int unsigned BLINK_DIV = 25000000,
    parameter bit          BLANK_LZ  = 1'b1
) (
    input  logic       Clock,
    input  logic       reset_n,
    input  logic [4:0] val1,
    input  logic [4:0] val2,
    input  logic [4:0] val3,
    input  logic [4:0] val4,
    input  logic [4:0] led_in,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [6:0] HEX6,
    output logic [6:0] HEX7,
    output logic [4:0] LEDR
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SUB,
        ST_DONE
    } state_t;

    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [25:0] DIV_LAST  = 26'(BLINK_DIV - 1);

    state_t     state, state_nxt;
    logic [1:0] ch, ch_nxt;
    logic [4:0] rem, rem_nxt;
    logic [1:0] tens, tens_nxt;
    logic [4:0] val_sel;
    logic       wr_en;
    logic [6:0] seg_tens;
    logic [6:0] seg_units;

    logic [25:0] blink_cnt;
    logic        blink_on;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        case (ch)
            2'd0:    val_sel = val1;
            2'd1:    val_sel = val2;
            2'd2:    val_sel = val3;
            default: val_sel = val4;
        endcase
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOAD;
            ch    <= 2'd0;
            rem   <= 5'd0;
            tens  <= 2'd0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            rem   <= rem_nxt;
            tens  <= tens_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        rem_nxt   = rem;
        tens_nxt  = tens;
        wr_en     = 1'b0;
        case (state)
            ST_LOAD: begin
                rem_nxt   = val_sel;
                tens_nxt  = 2'd0;
                state_nxt = ST_SUB;
            end
            ST_SUB: begin
                if (rem >= 5'd10) begin
                    rem_nxt  = rem - 5'd10;
                    tens_nxt = tens + 2'd1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                wr_en     = 1'b1;
                ch_nxt    = ch + 2'd1;
                state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // In DONE rem is already below ten, so the low nibble is the units digit.
    assign seg_units = seg7(rem[3:0]);
    assign seg_tens  = (BLANK_LZ && (tens == 2'd0)) ? SEG_BLANK : seg7({2'b00, tens});

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            HEX0 <= SEG_BLANK;
            HEX1 <= SEG_BLANK;
            HEX2 <= SEG_BLANK;
            HEX3 <= SEG_BLANK;
            HEX4 <= SEG_BLANK;
            HEX5 <= SEG_BLANK;
            HEX6 <= SEG_BLANK;
            HEX7 <= SEG_BLANK;
        end else if (wr_en) begin
            case (ch)
                2'd0: begin
                    HEX7 <= seg_tens;
                    HEX6 <= seg_units;
                end
                2'd1: begin
                    HEX5 <= seg_tens;
                    HEX4 <= seg_units;
                end
                2'd2: begin
                    HEX3 <= seg_tens;
                    HEX2 <= seg_units;
                end
                default: begin
                    HEX1 <= seg_tens;
                    HEX0 <= seg_units;
                end
            endcase
        end
    end

    // A zero result vector parks the blinker so the next non-zero value starts on.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= 26'd0;
            blink_on  <= 1'b1;
            LEDR      <= 5'd0;
        end else if (led_in == 5'd0) begin
            blink_cnt <= 26'd0;
            blink_on  <= 1'b1;
            LEDR      <= 5'd0;
        end else begin
            LEDR <= blink_on ? led_in : 5'd0;
            if (blink_cnt == DIV_LAST) begin
                blink_cnt <= 26'd0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end
        end
    end

endmodule
